// File: rtl/cora_spike_pkg.sv
// Shared spike-path definitions, used by the arbiter and by the
// button/utterance controller.
package cora_spike_pkg;

  localparam int unsigned N_CH   = 16;
  localparam int unsigned CH_W   = 4;
  localparam int unsigned DROP_W = 8;

  typedef logic [CH_W-1:0] ch_id_t;

endpackage : cora_spike_pkg

// File: rtl/spike_event_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans req starting at rr_ptr, wrapping modulo N_CH, and picks the first set bit.
//   req        : request vector
//   rr_ptr     : highest-priority channel this cycle
//   any_grant  : at least one request present
//   grant_mask : one-hot winner (0 when none)
//   grant_id   : binary winner index (0 when none)
module rr_arbiter #(
  parameter int unsigned N_CH = cora_spike_pkg::N_CH,
  parameter int unsigned CH_W = cora_spike_pkg::CH_W
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] rr_ptr,
  output logic            any_grant,
  output logic [N_CH-1:0] grant_mask,
  output logic [CH_W-1:0] grant_id
);

  // First requester at or after rr_ptr, in circular order.
  always_comb begin
    int unsigned idx;
    any_grant  = 1'b0;
    grant_mask = '0;
    grant_id   = '0;
    idx        = 0;
    for (int i = 0; i < int'(N_CH); i++) begin
      idx = (32'(rr_ptr) + 32'(i)) % N_CH;
      if (!any_grant && req[idx]) begin
        any_grant       = 1'b1;
        grant_mask[idx] = 1'b1;
        grant_id        = CH_W'(idx);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/spike_event_arbiter.sv
// Serialises per-channel spike pulses into one valid/ready event stream.
// Each channel owns a pending latch; the output register is refilled round-robin,
// and spikes that hit an already-pending (not being granted) channel are dropped
// and counted in a saturating counter with a sticky flag.
//   clk, rst_n   : clock, async active-low reset
//   spike_in     : single-cycle spike pulses, bit c = channel c
//   enable       : capture enable for spike_in
//   spike_ready  : downstream accept
//   clear_stats  : synchronous clear of drop_count / drop_flag
//   spike_valid  : event valid
//   channel_id   : channel of the current event
//   pending      : pending-latch vector (debug)
//   drop_count   : saturating count of dropped spikes
//   drop_flag    : sticky drop indicator
module spike_event_arbiter #(
  parameter int unsigned N_CH   = cora_spike_pkg::N_CH,
  parameter int unsigned CH_W   = cora_spike_pkg::CH_W,
  parameter int unsigned DROP_W = cora_spike_pkg::DROP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   spike_in,
  input  logic              enable,
  input  logic              spike_ready,
  input  logic              clear_stats,
  output logic              spike_valid,
  output logic [CH_W-1:0]   channel_id,
  output logic [N_CH-1:0]   pending,
  output logic [DROP_W-1:0] drop_count,
  output logic              drop_flag
);

  localparam int unsigned CNT_W = $clog2(N_CH + 1);
  localparam int unsigned SUM_W = ((DROP_W > CNT_W) ? DROP_W : CNT_W) + 1;

  logic [N_CH-1:0]   r_pending;
  logic              r_valid;
  logic [CH_W-1:0]   r_ch_id;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [DROP_W-1:0] r_drop_count;
  logic              r_drop_flag;

  logic              w_any;
  logic [N_CH-1:0]   w_arb_mask;
  logic [CH_W-1:0]   w_arb_id;
  logic              w_load;
  logic              w_grant;
  logic [N_CH-1:0]   w_grant_mask;
  logic [N_CH-1:0]   w_cap;
  logic [N_CH-1:0]   w_drop_vec;
  logic [CNT_W-1:0]  w_drop_num;
  logic [SUM_W-1:0]  w_drop_sum;
  logic [DROP_W-1:0] w_drop_sat;

  rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_rr_arbiter (
    .req        (r_pending),
    .rr_ptr     (r_rr_ptr),
    .any_grant  (w_any),
    .grant_mask (w_arb_mask),
    .grant_id   (w_arb_id)
  );

  // A grant happens only when the output register is free to load.
  assign w_load       = !r_valid || spike_ready;
  assign w_grant      = w_load && w_any;
  assign w_grant_mask = w_grant ? w_arb_mask : '0;
  assign w_cap        = enable ? spike_in : '0;
  // A spike on the channel being granted re-arms rather than drops.
  assign w_drop_vec   = w_cap & r_pending & ~w_grant_mask;

  // Drop popcount and saturating add.
  always_comb begin
    w_drop_num = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      w_drop_num = w_drop_num + CNT_W'(w_drop_vec[i]);
    end
    w_drop_sum = SUM_W'(r_drop_count) + SUM_W'(w_drop_num);
    if (w_drop_sum > SUM_W'({DROP_W{1'b1}})) begin
      w_drop_sat = {DROP_W{1'b1}};
    end else begin
      w_drop_sat = DROP_W'(w_drop_sum);
    end
  end

  // Pending latches and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_pending <= (r_pending & ~w_grant_mask) | w_cap;
      if (w_grant) begin
        if (w_arb_id == CH_W'(N_CH - 1)) begin
          r_rr_ptr <= '0;
        end else begin
          r_rr_ptr <= CH_W'(w_arb_id + CH_W'(1));
        end
      end
    end
  end

  // Output event register; channel_id holds its last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ch_id <= '0;
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_ch_id <= w_arb_id;
      end
    end
  end

  // Drop statistics; clear wins over same-cycle drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count <= '0;
      r_drop_flag  <= 1'b0;
    end else if (clear_stats) begin
      r_drop_count <= '0;
      r_drop_flag  <= 1'b0;
    end else if (|w_drop_vec) begin
      r_drop_count <= w_drop_sat;
      r_drop_flag  <= 1'b1;
    end
  end

  assign spike_valid = r_valid;
  assign channel_id  = r_ch_id;
  assign pending     = r_pending;
  assign drop_count  = r_drop_count;
  assign drop_flag   = r_drop_flag;

endmodule : spike_event_arbiter

// File: tb/tb_spike_event_arbiter.sv
// Directed bench for spike_event_arbiter: a vector table for single-cycle
// behaviour plus hand-written burst, saturation and reset sequences.
module tb_spike_event_arbiter;

  import cora_spike_pkg::*;

  typedef struct {
    logic [15:0] spk;
    logic        en;
    logic        rdy;
    logic        clr;
    logic        e_valid;
    logic [3:0]  e_id;
    logic [15:0] e_pend;
    logic [7:0]  e_dc;
    logic        e_df;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] spike_in;
  logic        enable;
  logic        spike_ready;
  logic        clear_stats;
  logic        spike_valid;
  ch_id_t      channel_id;
  logic [15:0] pending;
  logic [7:0]  drop_count;
  logic        drop_flag;

  int n_vec;
  int n_err;
  vec_t tv[$];

  spike_event_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spike_in    (spike_in),
    .enable      (enable),
    .spike_ready (spike_ready),
    .clear_stats (clear_stats),
    .spike_valid (spike_valid),
    .channel_id  (channel_id),
    .pending     (pending),
    .drop_count  (drop_count),
    .drop_flag   (drop_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] s, input logic e, input logic r, input logic c);
    spike_in    = s;
    enable      = e;
    spike_ready = r;
    clear_stats = c;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [3:0] id,
                         input logic [15:0] p, input logic [7:0] dc, input logic df);
    chk({tag, " valid"},   32'(spike_valid), 32'(v));
    chk({tag, " id"},      32'(channel_id),  32'(id));
    chk({tag, " pending"}, 32'(pending),     32'(p));
    chk({tag, " dcount"},  32'(drop_count),  32'(dc));
    chk({tag, " dflag"},   32'(drop_flag),   32'(df));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(16'h0, 1'b1, 1'b1, 1'b0);
    #3;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic [15:0] s, input logic e, input logic r, input logic c,
                              input logic v, input logic [3:0] id, input logic [15:0] p,
                              input logic [7:0] dc, input logic df);
    vec_t t;
    t.spk = s; t.en = e; t.rdy = r; t.clr = c;
    t.e_valid = v; t.e_id = id; t.e_pend = p; t.e_dc = dc; t.e_df = df;
    return t;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(16'h0, 1'b1, 1'b1, 1'b0);

    // Each row: inputs for one cycle, then outputs expected after that edge.
    // Backpressure, ch3 and ch9, pointer at 0.
    tv.push_back(mk(16'h0208, 1, 0, 0, 0, 4'd0, 16'h0208, 8'd0, 0));
    tv.push_back(mk(16'h0000, 1, 0, 0, 1, 4'd3, 16'h0200, 8'd0, 0));
    tv.push_back(mk(16'h0000, 1, 0, 0, 1, 4'd3, 16'h0200, 8'd0, 0));
    tv.push_back(mk(16'h0000, 1, 1, 0, 1, 4'd9, 16'h0000, 8'd0, 0));
    tv.push_back(mk(16'h0000, 1, 1, 0, 0, 4'd9, 16'h0000, 8'd0, 0));
    // Single spike on ch5: valid two edges after the pulse, one cycle wide.
    tv.push_back(mk(16'h0020, 1, 1, 0, 0, 4'd9, 16'h0020, 8'd0, 0));
    tv.push_back(mk(16'h0000, 1, 1, 0, 1, 4'd5, 16'h0000, 8'd0, 0));
    tv.push_back(mk(16'h0000, 1, 1, 0, 0, 4'd5, 16'h0000, 8'd0, 0));
    // Collisions on ch2 while the output is stalled, then clears.
    tv.push_back(mk(16'h0004, 1, 0, 0, 0, 4'd5, 16'h0004, 8'd0, 0));
    tv.push_back(mk(16'h0000, 1, 0, 0, 1, 4'd2, 16'h0000, 8'd0, 0));
    tv.push_back(mk(16'h0004, 1, 0, 0, 1, 4'd2, 16'h0004, 8'd0, 0));
    tv.push_back(mk(16'h0004, 1, 0, 0, 1, 4'd2, 16'h0004, 8'd1, 1));
    tv.push_back(mk(16'h0004, 1, 0, 0, 1, 4'd2, 16'h0004, 8'd2, 1));
    tv.push_back(mk(16'h0000, 1, 0, 1, 1, 4'd2, 16'h0004, 8'd0, 0));
    tv.push_back(mk(16'h0004, 1, 0, 1, 1, 4'd2, 16'h0004, 8'd0, 0));
    tv.push_back(mk(16'h0000, 1, 1, 0, 1, 4'd2, 16'h0000, 8'd0, 0));
    tv.push_back(mk(16'h0000, 1, 1, 0, 0, 4'd2, 16'h0000, 8'd0, 0));
    // Grant-cycle re-arm on ch4.
    tv.push_back(mk(16'h0010, 1, 1, 0, 0, 4'd2, 16'h0010, 8'd0, 0));
    tv.push_back(mk(16'h0010, 1, 1, 0, 1, 4'd4, 16'h0010, 8'd0, 0));
    tv.push_back(mk(16'h0000, 1, 1, 0, 1, 4'd4, 16'h0000, 8'd0, 0));
    tv.push_back(mk(16'h0000, 1, 1, 0, 0, 4'd4, 16'h0000, 8'd0, 0));
    // enable=0 blocks capture but pending still drains.
    tv.push_back(mk(16'h0001, 0, 1, 0, 0, 4'd4, 16'h0000, 8'd0, 0));
    tv.push_back(mk(16'h0100, 1, 1, 0, 0, 4'd4, 16'h0100, 8'd0, 0));
    tv.push_back(mk(16'h0100, 0, 1, 0, 1, 4'd8, 16'h0000, 8'd0, 0));
    tv.push_back(mk(16'h0000, 1, 1, 0, 0, 4'd8, 16'h0000, 8'd0, 0));
    // Multi-drop popcount and round-robin wrap from pointer 9.
    tv.push_back(mk(16'h0003, 1, 0, 0, 0, 4'd8, 16'h0003, 8'd0, 0));
    tv.push_back(mk(16'h0000, 1, 0, 0, 1, 4'd0, 16'h0002, 8'd0, 0));
    tv.push_back(mk(16'h0007, 1, 0, 0, 1, 4'd0, 16'h0007, 8'd1, 1));
    tv.push_back(mk(16'h0007, 1, 0, 0, 1, 4'd0, 16'h0007, 8'd4, 1));
    tv.push_back(mk(16'h0000, 1, 1, 1, 1, 4'd1, 16'h0005, 8'd0, 0));
    tv.push_back(mk(16'h0000, 1, 1, 0, 1, 4'd2, 16'h0001, 8'd0, 0));
    tv.push_back(mk(16'h0000, 1, 1, 0, 1, 4'd0, 16'h0000, 8'd0, 0));
    tv.push_back(mk(16'h0000, 1, 1, 0, 0, 4'd0, 16'h0000, 8'd0, 0));

    // Reset values.
    #2;
    chk_all("reset", 1'b0, 4'd0, 16'h0, 8'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step();
    foreach (tv[i]) begin
      drive(tv[i].spk, tv[i].en, tv[i].rdy, tv[i].clr);
      step();
      chk_all($sformatf("vec%0d", i), tv[i].e_valid, tv[i].e_id, tv[i].e_pend,
              tv[i].e_dc, tv[i].e_df);
    end

    // Burst fairness: two full bursts, each starting at id 0.
    @(negedge clk);
    do_reset();
    step();
    for (int b = 0; b < 2; b++) begin
      drive(16'hFFFF, 1'b1, 1'b1, 1'b0);
      step();
      drive(16'h0000, 1'b1, 1'b1, 1'b0);
      chk($sformatf("burst%0d pend", b), 32'(pending), 32'hFFFF);
      for (int k = 0; k < 16; k++) begin
        step();
        chk($sformatf("burst%0d ev%0d valid", b, k), 32'(spike_valid), 32'd1);
        chk($sformatf("burst%0d ev%0d id", b, k), 32'(channel_id), 32'(k));
      end
      step();
      chk($sformatf("burst%0d idle", b), 32'(spike_valid), 32'd0);
      chk($sformatf("burst%0d dcount", b), 32'(drop_count), 32'd0);
    end

    // Saturation: first edge captures, second grants ch0 and drops 15,
    // then every stalled cycle drops 16.
    begin
      int exp_dc;
      exp_dc = 0;
      for (int k = 0; k < 22; k++) begin
        drive(16'hFFFF, 1'b1, 1'b0, 1'b0);
        step();
        if (k == 1) exp_dc = 15;
        else if (k > 1) exp_dc = exp_dc + 16;
        if (exp_dc > 255) exp_dc = 255;
        chk($sformatf("sat%0d dcount", k), 32'(drop_count), 32'(exp_dc));
      end
      chk("sat flag", 32'(drop_flag), 32'd1);
      chk("sat valid", 32'(spike_valid), 32'd1);
    end

    // Asynchronous reset mid-burst.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("midreset", 1'b0, 4'd0, 16'h0, 8'd0, 1'b0);
    drive(16'h0000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("postreset%0d valid", k), 32'(spike_valid), 32'd0);
    end
    // Pointer also back at 0: ch0 wins over ch15.
    drive(16'h8001, 1'b1, 1'b1, 1'b0);
    step();
    drive(16'h0000, 1'b1, 1'b1, 1'b0);
    step();
    chk("postreset first id", 32'(channel_id), 32'd0);
    step();
    chk("postreset second id", 32'(channel_id), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_spike_event_arbiter
